// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input and valid/ready word output bundle of the deserializer.
interface sipo_deserializer_if #(parameter int WIDTH = 8);
  logic serial_in;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic frame_err;
  logic overrun;
  logic parity_err;
  modport master (
    output serial_in, out_ready,
    input  out_data, out_valid, frame_err, overrun, parity_err
  );
  modport slave (
    input  serial_in, out_ready,
    output out_data, out_valid, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: start/data/stop frame to parallel word on valid/ready; PARITY_CHECK_EN adds an even-parity bit.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic clear_n,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic par_bad;
  logic perr_q;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_q;
  logic valid_q;
  logic ferr_q;
  logic ovr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
      // a plain accept clears valid; a good word loaded at STOP below overrides this
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!bus.serial_in) state <= DATA;
        end
        DATA: begin
          shreg[cnt] <= bus.serial_in;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt <= '0;
`ifdef PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          par_bad <= ^shreg ^ bus.serial_in;
          state   <= STOP;
        end
`endif
        STOP: begin
          state <= IDLE;
          if (!bus.serial_in) ferr_q <= 1'b1;
`ifdef PARITY_CHECK_EN
          else if (par_bad) perr_q <= 1'b1;
`endif
          else if (!valid_q || bus.out_ready) begin
            data_q  <= shreg;
            valid_q <= 1'b1;
          end else ovr_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed frames with hand-computed expectations for sipo_deserializer.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int errors = 0;
  int checks = 0;
  sipo_deserializer_if #(.WIDTH(8)) bus ();
  sipo_deserializer #(.WIDTH(8)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bus.serial_in = b;
    tick();
  endtask
  // full frame; out_ready is raised only for the stop-bit edge when rdy_stop=1
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic rdy_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("note: parity ignored");
`endif
    bus.out_ready = rdy_stop;
    send_bit(stop);
    bus.out_ready = 1'b0;
  endtask
  task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic fe, input logic ov, input logic pe);
    check({tag, ".data"}, 32'(bus.out_data), 32'(d));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(ov));
    check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(pe));
  endtask
  task automatic accept();
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.serial_in = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_n = 1'b1;
    send_bit(1'b1);
    check_outs("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    clear_n = 1'b0;
    send_bit(1'b1);
    clear_n = 1'b1;
    check_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_outs("after_reset_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    check("a5_accepted", 32'(bus.out_valid), 32'd0);
    // single frame with latency and hold
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    check("3c_not_early", 32'(bus.out_valid), 32'd0);
    send_bit(1'b1);
    check_outs("3c_stop", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      check("3c_hold_valid", 32'(bus.out_valid), 32'd1);
      check("3c_hold_data", 32'(bus.out_data), 32'h3C);
    end
    accept();
    check("3c_cleared", 32'(bus.out_valid), 32'd0);
    // framing error
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check_outs("ferr", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    check("ferr_one_cycle", 32'(bus.frame_err), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    check_outs("after_ferr_12", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    // overrun on back-to-back frames
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    check_outs("ovr_first", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 1'b0);
    check_outs("ovr_second", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1);
    check_outs("ovr_after", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    // same-edge accept and reload
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'(8'h02 >> i));
      check("swap_valid_held", 32'(bus.out_valid), 32'd1);
    end
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    bus.out_ready = 1'b0;
    check_outs("swap_stop", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    check_outs("swap_hold", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    check("swap_cleared", 32'(bus.out_valid), 32'd0);
`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_outs("par_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    check_outs("par_bad", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    check("par_bad_one_cycle", 32'(bus.parity_err), 32'd0);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    check_outs("par_bad_stop0", 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
